// File: rtl/zinde_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and the default
// stream terminator byte.
package zinde_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam logic [7:0] END_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/boot_ctrl.sv
// Boot loader: streams program bytes into a shared 256-byte RAM, then hands the
// RAM port to the CPU and releases it from hold.
module boot_ctrl
   import zinde_pkg::*;
#(
   parameter logic [7:0] END_BYTE = END_BYTE_DEFAULT
) (
   input  logic       clkn,
   input  logic       rstn,
   input  logic       start,
   input  logic [7:0] base_adr,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   input  logic [7:0] cpu_adr,
   input  logic [7:0] cpu_data,
   input  logic       cpu_we,
   output logic [7:0] mem_adr,
   output logic [7:0] mem_data,
   output logic       mem_we,
   output logic       sel,
   output logic       cpu_run,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] byte_cnt
);

   state_e     state_q, state_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] wr_adr_q, wr_adr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       wr_vld_q, wr_vld_d;
   logic       done_q, done_d;

   always_ff @(posedge clkn or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         wr_adr_q  <= '0;
         wr_data_q <= '0;
         wr_vld_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         wr_adr_q  <= wr_adr_d;
         wr_data_q <= wr_data_d;
         wr_vld_q  <= wr_vld_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      wr_adr_d  = wr_adr_q;
      wr_data_d = wr_data_q;
      wr_vld_d  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (start) begin
               state_d = ST_LOAD;
               ptr_d   = base_adr;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            // s_ready is constant 1 here, so s_valid alone marks a handshake
            if (s_valid) begin
               if (s_data == END_BYTE) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end else begin
                  wr_vld_d  = 1'b1;
                  wr_adr_d  = ptr_q;
                  wr_data_d = s_data;
                  ptr_d     = ptr_q + 8'd1;
                  cnt_d     = cnt_q + 8'd1;
                  if (ptr_q == 8'hFF) state_d = ST_ERR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outside RUN the RAM port follows the write register only; the final
   // write to 0xFF therefore still lands during the first ERR cycle.
   always_comb begin
      sel      = 1'b1;
      cpu_run  = 1'b0;
      s_ready  = 1'b0;
      busy     = 1'b0;
      err      = 1'b0;
      mem_adr  = wr_adr_q;
      mem_data = wr_data_q;
      mem_we   = wr_vld_q;
      case (state_q)
         ST_LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         ST_RUN: begin
            sel      = 1'b0;
            cpu_run  = 1'b1;
            mem_adr  = cpu_adr;
            mem_data = cpu_data;
            mem_we   = cpu_we;
         end
         ST_ERR:  err = 1'b1;
         default: ;
      endcase
   end

   assign done     = done_q;
   assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: directed scenarios plus randomized loads
// checked against a list-based model of the expected RAM image and status.
module tb_boot_ctrl;
   import zinde_pkg::*;

   localparam logic [7:0] END_B = 8'hFF;

   logic       clkn = 1'b0;
   logic       rstn = 1'b1;
   logic       start = 1'b0;
   logic [7:0] base_adr = '0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_ready;
   logic [7:0] cpu_adr = '0;
   logic [7:0] cpu_data = '0;
   logic       cpu_we = 1'b0;
   logic [7:0] mem_adr, mem_data, byte_cnt;
   logic       mem_we, sel, cpu_run, busy, done, err;

   int checks = 0;
   int failures = 0;

   logic [7:0] ram     [256];
   logic [7:0] exp_ram [256];
   logic       fill_req = 1'b0;
   int         done_cnt = 0, both_cnt = 0, lat_bad = 0, hs_cnt = 0;
   logic       hs_prev = 1'b0;

   logic [7:0] stream [$];
   int         exp_cnt, exp_acc;
   bit         exp_err, exp_done;

   always #5 clkn = ~clkn;

   boot_ctrl #(.END_BYTE(END_B)) dut (
      .clkn(clkn), .rstn(rstn), .start(start), .base_adr(base_adr),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .cpu_adr(cpu_adr), .cpu_data(cpu_data), .cpu_we(cpu_we),
      .mem_adr(mem_adr), .mem_data(mem_data), .mem_we(mem_we),
      .sel(sel), .cpu_run(cpu_run), .busy(busy), .done(done), .err(err),
      .byte_cnt(byte_cnt)
   );

   // The shared RAM lives in the bench
   always @(posedge clkn) begin
      if (fill_req) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      end else if (mem_we) begin
         ram[mem_adr] <= mem_data;
      end
   end

   // Observers: loader write must follow a data handshake by exactly one cycle
   always @(posedge clkn) begin
      if (!rstn) begin
         hs_prev <= 1'b0;
      end else begin
         if (sel && (mem_we !== hs_prev)) lat_bad <= lat_bad + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (done && err) both_cnt <= both_cnt + 1;
         if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
         hs_prev <= s_valid && s_ready && (s_data != END_B);
      end
   end

   task automatic step();
      @(posedge clkn);
      #1;
   endtask

   task automatic fill_ram();
      fill_req = 1'b1;
      step();
      fill_req = 1'b0;
      for (int i = 0; i < 256; i++) exp_ram[i] = 8'(i) ^ 8'h5A;
   endtask

   function automatic int ram_diff();
      int n = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) n++;
      return n;
   endfunction

   // Reference: walk the byte list, writing upward from base until the
   // terminator or until the byte written at 0xFF.
   task automatic model_load(input logic [7:0] base);
      int a;
      a = int'(base);
      exp_cnt = 0; exp_acc = 0; exp_err = 1'b0; exp_done = 1'b0;
      foreach (stream[i]) begin
         exp_acc++;
         if (stream[i] == END_B) begin
            exp_done = 1'b1;
            break;
         end
         exp_ram[a] = stream[i];
         exp_cnt++;
         if (a == 255) begin
            exp_err = 1'b1;
            break;
         end
         a++;
      end
   endtask

   task automatic drive_stream(input int gap_mode, input bit noise, output int acc);
      acc = 0;
      foreach (stream[i]) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            step();
         end
         s_valid = 1'b1;
         s_data  = stream[i];
         if (s_ready !== 1'b1) break;
         if (noise && $urandom_range(0, 3) == 0) begin
            start    = 1'b1;
            base_adr = 8'($urandom);
         end
         step();
         start = 1'b0;
         acc++;
      end
      s_valid = 1'b0;
   endtask

   task automatic run_load(input string name, input logic [7:0] base, input int gap_mode,
                           input bit noise);
      int acc, d0, bad;
      base_adr = base;
      start    = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({busy, sel, cpu_run, s_ready, err} !== 5'b11010) begin
         failures++;
         $display("FAIL %s load_entry: got busy/sel/run/rdy/err=%b expected 11010", name,
                  {busy, sel, cpu_run, s_ready, err});
      end
      model_load(base);
      d0 = done_cnt;
      drive_stream(gap_mode, noise, acc);
      checks++;
      if (done !== exp_done) begin
         failures++;
         $display("FAIL %s done_now: got %b expected %b", name, done, exp_done);
      end
      step();
      checks++;
      if (acc !== exp_acc) begin
         failures++;
         $display("FAIL %s accepted: got %0d expected %0d", name, acc, exp_acc);
      end
      bad = ram_diff();
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL %s ram_contents: got %0d differing bytes expected 0", name, bad);
      end
      checks++;
      if (byte_cnt !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL %s byte_cnt: got %0d expected %0d", name, byte_cnt, exp_cnt);
      end
      checks++;
      if ({err, cpu_run, sel, busy} !== {exp_err, ~exp_err, exp_err, 1'b0}) begin
         failures++;
         $display("FAIL %s end_state: got err/run/sel/busy=%b expected %b", name,
                  {err, cpu_run, sel, busy}, {exp_err, ~exp_err, exp_err, 1'b0});
      end
      checks++;
      if (done_cnt - d0 !== int'(exp_done)) begin
         failures++;
         $display("FAIL %s done_pulses: got %0d expected %0d", name, done_cnt - d0,
                  int'(exp_done));
      end
      checks++;
      if (lat_bad !== 0) begin
         failures++;
         $display("FAIL %s write_timing: got %0d bad cycles expected 0", name, lat_bad);
      end
   endtask

   task automatic test_reset();
      int h0;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({sel, cpu_run, s_ready, mem_we, busy, done, err, mem_adr, mem_data, byte_cnt}
          !== {7'b1000000, 24'h0}) begin
         failures++;
         $display("FAIL reset_outs: got %h expected %h",
                  {sel, cpu_run, s_ready, mem_we, busy, done, err, mem_adr, mem_data, byte_cnt},
                  {7'b1000000, 24'h0});
      end
      fill_ram();
      step();
      rstn = 1'b1;
      h0 = hs_cnt;
      s_valid = 1'b1;
      s_data  = 8'h12;
      repeat (3) step();
      s_valid = 1'b0;
      checks++;
      if ({s_ready, busy, sel, cpu_run, hs_cnt - h0} !== {4'b0010, 32'd0}) begin
         failures++;
         $display("FAIL idle_hold: got rdy/busy/sel/run=%b hs=%0d expected 0010 hs=0",
                  {s_ready, busy, sel, cpu_run}, hs_cnt - h0);
      end
   endtask

   task automatic test_idle_start_valid();
      int h0;
      h0 = hs_cnt;
      base_adr = 8'h80;
      start    = 1'b1;
      s_valid  = 1'b1;
      s_data   = 8'h77;
      step();
      start   = 1'b0;
      s_valid = 1'b0;
      checks++;
      if ({busy, hs_cnt - h0} !== {1'b1, 32'd0}) begin
         failures++;
         $display("FAIL idle_start_byte: got busy=%b hs=%0d expected busy=1 hs=0", busy,
                  hs_cnt - h0);
      end
      s_valid = 1'b1;
      s_data  = END_B;
      step();
      s_valid = 1'b0;
      step();
      checks++;
      if ({byte_cnt, ram[8'h80], cpu_run} !== {8'd0, exp_ram[8'h80], 1'b1}) begin
         failures++;
         $display("FAIL empty_load: got cnt=%0d ram80=%h run=%b expected cnt=0 ram80=%h run=1",
                  byte_cnt, ram[8'h80], cpu_run, exp_ram[8'h80]);
      end
   endtask

   task automatic test_load_basic();
      fill_ram();
      stream = '{8'h32, 8'h05, 8'h46, 8'h50, 8'h44, 8'h60, 8'h0F, 8'hFF};
      run_load("basic", 8'h10, 0, 1'b0);
      checks++;
      if ({ram[8'h10], ram[8'h16], ram[8'h17]} !== {8'h32, 8'h0F, 8'h17 ^ 8'h5A}) begin
         failures++;
         $display("FAIL basic_ends: got %h expected %h", {ram[8'h10], ram[8'h16], ram[8'h17]},
                  {8'h32, 8'h0F, 8'h17 ^ 8'h5A});
      end
   endtask

   task automatic test_cpu_access();
      cpu_adr  = 8'h50;
      cpu_data = 8'h09;
      cpu_we   = 1'b1;
      #1;
      checks++;
      if ({mem_adr, mem_data, mem_we} !== {8'h50, 8'h09, 1'b1}) begin
         failures++;
         $display("FAIL cpu_passthru: got %h expected %h", {mem_adr, mem_data, mem_we},
                  {8'h50, 8'h09, 1'b1});
      end
      step();
      cpu_we  = 1'b0;
      cpu_adr = 8'h33;
      exp_ram[8'h50] = 8'h09;
      #1;
      checks++;
      if ({ram[8'h50], mem_adr, mem_we} !== {8'h09, 8'h33, 1'b0}) begin
         failures++;
         $display("FAIL cpu_write: got %h expected %h", {ram[8'h50], mem_adr, mem_we},
                  {8'h09, 8'h33, 1'b0});
      end
   endtask

   task automatic test_reload();
      stream = '{8'h01, 8'hFF};
      run_load("reload", 8'h20, 0, 1'b0);
   endtask

   task automatic test_overflow();
      fill_ram();
      stream = '{8'hAA, 8'hBB, 8'hCC};
      run_load("overflow", 8'hFE, 0, 1'b0);
      cpu_adr  = 8'h00;
      cpu_data = 8'h11;
      cpu_we   = 1'b1;
      #1;
      checks++;
      if ({mem_we, sel, err, done} !== 4'b0110) begin
         failures++;
         $display("FAIL err_cpu_block: got we/sel/err/done=%b expected 0110",
                  {mem_we, sel, err, done});
      end
      step();
      cpu_we = 1'b0;
      step();
      checks++;
      if ({ram[8'h00], ram[8'hFE], ram[8'hFF]} !== {8'h5A, 8'hAA, 8'hBB}) begin
         failures++;
         $display("FAIL overflow_ram: got %h expected %h", {ram[8'h00], ram[8'hFE], ram[8'hFF]},
                  {8'h5A, 8'hAA, 8'hBB});
      end
   endtask

   task automatic test_gapped();
      fill_ram();
      stream = '{8'h32, 8'h05, 8'h46, 8'h50, 8'h44, 8'h60, 8'h0F, 8'hFF};
      run_load("gapped", 8'h10, 1, 1'b0);
   endtask

   task automatic test_reset_abort();
      logic [7:0] b [4];
      int h0;
      fill_ram();
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 254));
      base_adr = 8'h40;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         s_valid = 1'b1;
         s_data  = b[k];
         step();
      end
      s_data = b[3];
      rstn   = 1'b0;
      #1;
      checks++;
      if ({sel, cpu_run, s_ready, mem_we, busy, done, err, mem_adr, mem_data, byte_cnt}
          !== {7'b1000000, 24'h0}) begin
         failures++;
         $display("FAIL abort_outs: got %h expected %h",
                  {sel, cpu_run, s_ready, mem_we, busy, done, err, mem_adr, mem_data, byte_cnt},
                  {7'b1000000, 24'h0});
      end
      repeat (2) step();
      rstn = 1'b1;
      h0 = hs_cnt;
      repeat (2) step();
      s_valid = 1'b0;
      checks++;
      if ({s_ready, busy, hs_cnt - h0} !== {2'b00, 32'd0}) begin
         failures++;
         $display("FAIL abort_idle: got rdy/busy=%b hs=%0d expected 00 hs=0", {s_ready, busy},
                  hs_cnt - h0);
      end
      checks++;
      if ({ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]}
          !== {b[0], b[1], exp_ram[8'h42], exp_ram[8'h43]}) begin
         failures++;
         $display("FAIL abort_ram: got %h expected %h",
                  {ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]},
                  {b[0], b[1], exp_ram[8'h42], exp_ram[8'h43]});
      end
      exp_ram[8'h40] = b[0];
      exp_ram[8'h41] = b[1];
   endtask

   task automatic test_random();
      logic [7:0] base, a, d;
      int len;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 4) == 0) fill_ram();
         if (cpu_run === 1'b1 && $urandom_range(0, 1) == 1) begin
            a = 8'($urandom);
            d = 8'($urandom);
            cpu_adr  = a;
            cpu_data = d;
            cpu_we   = 1'b1;
            step();
            cpu_we = 1'b0;
            exp_ram[a] = d;
         end
         base = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF0, 8'hFF))
                                            : 8'($urandom);
         len = $urandom_range(0, 14);
         stream.delete();
         for (int k = 0; k < len; k++) stream.push_back(8'($urandom_range(0, 254)));
         stream.push_back(END_B);
         run_load($sformatf("rand%0d", it), base, $urandom_range(0, 2), 1'b1);
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_cnt !== 0) begin
         failures++;
         $display("FAIL done_err_excl: got %0d overlap cycles expected 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_idle_start_valid();
      test_load_basic();
      test_cpu_access();
      test_reload();
      test_overflow();
      test_gapped();
      test_reset_abort();
      test_random();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
